// File: rtl/periph_master_arbiter.sv
// Round-robin arbiter sharing the peripheral demux master port between NB_MASTERS requesters.
// Optional response timeout enabled by defining PERIPH_ARB_TIMEOUT_EN.
module periph_master_arbiter #(
   parameter int unsigned NB_MASTERS     = 3,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH       = 10,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                             clk,
   input  logic                             rst_ni,
   input  logic [NB_MASTERS-1:0]            m_req_i,
   input  logic [NB_MASTERS*ADDR_WIDTH-1:0] m_add_i,
   input  logic [NB_MASTERS-1:0]            m_wen_i,
   input  logic [NB_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
   input  logic [NB_MASTERS*BE_WIDTH-1:0]   m_be_i,
   output logic [NB_MASTERS-1:0]            m_gnt_o,
   output logic [NB_MASTERS-1:0]            m_r_valid_o,
   output logic [DATA_WIDTH-1:0]            m_r_rdata_o,
   output logic                             data_req_o,
   output logic [ADDR_WIDTH-1:0]            data_add_o,
   output logic                             data_wen_o,
   output logic [DATA_WIDTH-1:0]            data_wdata_o,
   output logic [BE_WIDTH-1:0]              data_be_o,
   output logic [ID_WIDTH-1:0]              data_ID_o,
   input  logic                             data_gnt_i,
   input  logic                             data_r_valid_i,
   input  logic [DATA_WIDTH-1:0]            data_r_rdata_i,
   output logic                             timeout_o
);

   localparam int unsigned IDX_W = $clog2(NB_MASTERS);

   typedef enum logic {IDLE, WAIT_RESP} state_e;

   state_e             state_q, state_d;
   logic               locked_q;
   logic [IDX_W-1:0]   rr_ptr_q, sel_q, winner, sel, rr_next;
   logic               req_ok, data_req, grant, resp, expire, done;

   logic [ADDR_WIDTH-1:0] add_arr   [NB_MASTERS];
   logic [DATA_WIDTH-1:0] wdata_arr [NB_MASTERS];
   logic [BE_WIDTH-1:0]   be_arr    [NB_MASTERS];

   for (genvar g = 0; g < NB_MASTERS; g++) begin : g_unpack
      assign add_arr[g]   = m_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign be_arr[g]    = m_be_i[g*BE_WIDTH +: BE_WIDTH];
   end

   // Scan downwards so the last hit is the first requester at or after rr_ptr.
   always_comb begin
      logic [IDX_W-1:0] scan_idx;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      scan_idx = '0;
      winner   = rr_ptr_q;
      for (int i = NB_MASTERS - 1; i >= 0; i--) begin
         scan_idx = IDX_W'((int'(rr_ptr_q) + i) % NB_MASTERS);
         if (m_req_i[scan_idx]) winner = scan_idx;
      end
   end

   assign sel      = locked_q ? sel_q : winner;
   assign req_ok   = locked_q ? m_req_i[sel_q] : |m_req_i;
   assign data_req = (state_q == IDLE) && req_ok;
   assign grant    = data_req && data_gnt_i;
   assign resp     = (state_q == WAIT_RESP) && data_r_valid_i;
   assign done     = resp || expire;
   assign rr_next  = (sel_q == IDX_W'(NB_MASTERS - 1)) ? '0 : sel_q + 1'b1;

`ifdef PERIPH_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] tmo_cnt_q;

   assign expire = (state_q == WAIT_RESP) && !data_r_valid_i &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) tmo_cnt_q <= '0;
      else if (grant) tmo_cnt_q <= '0;
      else if (state_q == WAIT_RESP && !data_r_valid_i && !expire) tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expire         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (grant) state_d = WAIT_RESP;
         WAIT_RESP: if (done)  state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Lock holds the selection stable while the demux withholds its grant.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         locked_q <= 1'b0;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         if (state_q == IDLE) begin
            if (grant) begin
               sel_q    <= sel;
               locked_q <= 1'b0;
            end else if (locked_q && !m_req_i[sel_q]) begin
               locked_q <= 1'b0;
            end else if (!locked_q && req_ok) begin
               sel_q    <= winner;
               locked_q <= 1'b1;
            end
         end
         if (done) rr_ptr_q <= rr_next;
      end
   end

   always_comb begin
      data_req_o   = 1'b0;
      data_add_o   = '0;
      data_wen_o   = 1'b0;
      data_wdata_o = '0;
      data_be_o    = '0;
      data_ID_o    = '0;
      m_gnt_o      = '0;
      m_r_valid_o  = '0;
      m_r_rdata_o  = '0;
      timeout_o    = 1'b0;
      if (data_req) begin
         data_req_o   = 1'b1;
         data_add_o   = add_arr[sel];
         data_wen_o   = m_wen_i[sel];
         data_wdata_o = wdata_arr[sel];
         data_be_o    = be_arr[sel];
         data_ID_o    = ID_WIDTH'(sel);
         if (data_gnt_i) m_gnt_o[sel] = 1'b1;
      end
      if (resp) begin
         m_r_valid_o[sel_q] = 1'b1;
         m_r_rdata_o        = data_r_rdata_i;
      end
`ifdef PERIPH_ARB_TIMEOUT_EN
      if (expire) begin
         m_r_valid_o[sel_q] = 1'b1;
         m_r_rdata_o        = DATA_WIDTH'(32'hDEAD_BEEF);
         timeout_o          = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_periph_master_arbiter.sv
// Directed bench for periph_master_arbiter: vector table plus reset, round-robin and timeout sequences.
module tb_periph_master_arbiter;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h1A30_0004;
   localparam logic [31:0] A2 = 32'h2000_0008;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [2:0]  m_req_i = '0;
   logic [95:0] m_add_i;
   logic [2:0]  m_wen_i;
   logic [95:0] m_wdata_i;
   logic [11:0] m_be_i;
   logic [2:0]  m_gnt_o, m_r_valid_o;
   logic [31:0] m_r_rdata_o;
   logic        data_req_o, data_wen_o, data_gnt_i = 1'b0, data_r_valid_i = 1'b0, timeout_o;
   logic [31:0] data_add_o, data_wdata_o, data_r_rdata_i = '0;
   logic [3:0]  data_be_o;
   logic [9:0]  data_ID_o;

   int total = 0;
   int bad = 0;

   logic [31:0] wd_tab [3];
   logic [3:0]  be_tab [3];

   typedef struct {
      logic [2:0]  req;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic [2:0]  e_gnt;
      logic [2:0]  e_rv;
      logic [31:0] e_rdata;
      logic        e_req;
      logic [31:0] e_add;
      logic        e_wen;
      logic [9:0]  e_id;
   } vec_t;

   vec_t vecs [20];

   periph_master_arbiter #(.NB_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
                           .ID_WIDTH(10), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
      .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
      .m_r_rdata_o(m_r_rdata_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
      .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
      .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
      .data_r_rdata_i(data_r_rdata_i), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
   task automatic cyc(input logic [2:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      m_req_i        = req;
      data_gnt_i     = gnt;
      data_r_valid_i = rv;
      data_r_rdata_i = rdata;
      @(negedge clk);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      m_req_i = '0; data_gnt_i = 1'b0; data_r_valid_i = 1'b0; data_r_rdata_i = '0;
      rst_ni = 1'b0;
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      wd_tab = '{32'h0000_00A0, 32'h0000_00B1, 32'h0000_00C2};
      be_tab = '{4'h1, 4'h3, 4'hF};
      m_add_i   = {A2, A1, A0};
      m_wen_i   = 3'b101;
      m_wdata_i = {wd_tab[2], wd_tab[1], wd_tab[0]};
      m_be_i    = {be_tab[2], be_tab[1], be_tab[0]};

      //          req     gnt  rv   rdata          e_gnt   e_rv    e_rdata        e_req e_add e_wen e_id
      vecs[0]  = '{3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 32'h0,          0, 32'h0, 0, 10'd0};
      vecs[1]  = '{3'b010, 1, 0, 32'h0,          3'b010, 3'b000, 32'h0,          1, A1,    0, 10'd1};
      vecs[2]  = '{3'b000, 0, 1, 32'h55,         3'b000, 3'b010, 32'h55,         0, 32'h0, 0, 10'd0};
      vecs[3]  = '{3'b000, 0, 1, 32'h99,         3'b000, 3'b000, 32'h0,          0, 32'h0, 0, 10'd0};
      vecs[4]  = '{3'b111, 1, 0, 32'h0,          3'b100, 3'b000, 32'h0,          1, A2,    1, 10'd2};
      vecs[5]  = '{3'b000, 0, 1, 32'h66,         3'b000, 3'b100, 32'h66,         0, 32'h0, 0, 10'd0};
      vecs[6]  = '{3'b100, 0, 0, 32'h0,          3'b000, 3'b000, 32'h0,          1, A2,    1, 10'd2};
      vecs[7]  = '{3'b101, 0, 0, 32'h0,          3'b000, 3'b000, 32'h0,          1, A2,    1, 10'd2};
      vecs[8]  = '{3'b101, 0, 0, 32'h0,          3'b000, 3'b000, 32'h0,          1, A2,    1, 10'd2};
      vecs[9]  = '{3'b101, 0, 0, 32'h0,          3'b000, 3'b000, 32'h0,          1, A2,    1, 10'd2};
      vecs[10] = '{3'b101, 1, 0, 32'h0,          3'b100, 3'b000, 32'h0,          1, A2,    1, 10'd2};
      vecs[11] = '{3'b101, 1, 0, 32'h0,          3'b000, 3'b000, 32'h0,          0, 32'h0, 0, 10'd0};
      vecs[12] = '{3'b001, 0, 1, 32'h1234_5678,  3'b000, 3'b100, 32'h1234_5678,  0, 32'h0, 0, 10'd0};
      vecs[13] = '{3'b001, 1, 0, 32'h0,          3'b001, 3'b000, 32'h0,          1, A0,    1, 10'd0};
      vecs[14] = '{3'b000, 0, 1, 32'h1234_5678,  3'b000, 3'b001, 32'h1234_5678,  0, 32'h0, 0, 10'd0};
      vecs[15] = '{3'b000, 0, 0, 32'hFFFF,       3'b000, 3'b000, 32'h0,          0, 32'h0, 0, 10'd0};
      vecs[16] = '{3'b001, 0, 0, 32'h0,          3'b000, 3'b000, 32'h0,          1, A0,    1, 10'd0};
      vecs[17] = '{3'b000, 1, 0, 32'h0,          3'b000, 3'b000, 32'h0,          0, 32'h0, 0, 10'd0};
      vecs[18] = '{3'b010, 1, 0, 32'h0,          3'b010, 3'b000, 32'h0,          1, A1,    0, 10'd1};
      vecs[19] = '{3'b000, 0, 1, 32'hAB,         3'b000, 3'b010, 32'hAB,         0, 32'h0, 0, 10'd0};

      // Reset state while rst_ni is still low.
      #2;
      check("rst gnt", 64'(m_gnt_o), 64'h0);
      check("rst rvalid", 64'(m_r_valid_o), 64'h0);
      check("rst rdata", 64'(m_r_rdata_o), 64'h0);
      check("rst req", 64'(data_req_o), 64'h0);
      check("rst timeout", 64'(timeout_o), 64'h0);
      reset_dut();

      for (int i = 0; i < 20; i++) begin
         cyc(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
         check($sformatf("v%0d gnt", i),    64'(m_gnt_o),     64'(vecs[i].e_gnt));
         check($sformatf("v%0d rvalid", i), 64'(m_r_valid_o), 64'(vecs[i].e_rv));
         check($sformatf("v%0d rdata", i),  64'(m_r_rdata_o), 64'(vecs[i].e_rdata));
         check($sformatf("v%0d req", i),    64'(data_req_o),  64'(vecs[i].e_req));
         check($sformatf("v%0d add", i),    64'(data_add_o),  64'(vecs[i].e_add));
         check($sformatf("v%0d wen", i),    64'(data_wen_o),  64'(vecs[i].e_wen));
         check($sformatf("v%0d id", i),     64'(data_ID_o),   64'(vecs[i].e_id));
         check($sformatf("v%0d wdata", i),  64'(data_wdata_o),
               vecs[i].e_req ? 64'(wd_tab[vecs[i].e_id[1:0]]) : 64'h0);
         check($sformatf("v%0d be", i),     64'(data_be_o),
               vecs[i].e_req ? 64'(be_tab[vecs[i].e_id[1:0]]) : 64'h0);
         check($sformatf("v%0d timeout", i), 64'(timeout_o), 64'h0);
      end

      // Reset while waiting for a response: rr_ptr is 2 here, master 1 gets granted.
      cyc(3'b010, 1, 0, 32'h0);
      check("mid gnt", 64'(m_gnt_o), 64'h2);
      @(posedge clk);
      #1;
      m_req_i = 3'b000; data_gnt_i = 1'b0; data_r_valid_i = 1'b1; data_r_rdata_i = 32'h5A5A;
      rst_ni = 1'b0;
      #1;
      check("mid rst rvalid", 64'(m_r_valid_o), 64'h0);
      check("mid rst rdata", 64'(m_r_rdata_o), 64'h0);
      check("mid rst req", 64'(data_req_o), 64'h0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(negedge clk);
      check("post rst rvalid", 64'(m_r_valid_o), 64'h0);
      check("post rst rdata", 64'(m_r_rdata_o), 64'h0);
      cyc(3'b111, 1, 0, 32'h0);
      check("post rst rr gnt", 64'(m_gnt_o), 64'h1);
      cyc(3'b000, 0, 1, 32'h77);
      check("post rst rvalid2", 64'(m_r_valid_o), 64'h1);

      // All masters request continuously; slave grants and responds every cycle.
      reset_dut();
      for (int c = 0; c < 10; c++) begin
         cyc(3'b111, 1, 1, 32'h100 + 32'(c));
         if (c % 2 == 0) begin
            check($sformatf("rr c%0d gnt", c), 64'(m_gnt_o), 64'(3'b001 << ((c / 2) % 3)));
            check($sformatf("rr c%0d rvalid", c), 64'(m_r_valid_o), 64'h0);
            check($sformatf("rr c%0d rdata", c), 64'(m_r_rdata_o), 64'h0);
         end else begin
            check($sformatf("rr c%0d gnt", c), 64'(m_gnt_o), 64'h0);
            check($sformatf("rr c%0d rvalid", c), 64'(m_r_valid_o), 64'(3'b001 << (((c - 1) / 2) % 3)));
            check($sformatf("rr c%0d rdata", c), 64'(m_r_rdata_o), 64'h100 + 64'(c));
         end
      end

`ifdef PERIPH_ARB_TIMEOUT_EN
      // rr_ptr is 2 after the loop above; master 2 issues and the slave never answers.
      cyc(3'b100, 1, 0, 32'h0);
      check("tmo gnt", 64'(m_gnt_o), 64'h4);
      for (int w = 1; w < 8; w++) begin
         cyc(3'b000, 0, 0, 32'h0);
         check($sformatf("tmo w%0d rvalid", w), 64'(m_r_valid_o), 64'h0);
         check($sformatf("tmo w%0d timeout", w), 64'(timeout_o), 64'h0);
      end
      cyc(3'b000, 0, 0, 32'h0);
      check("tmo expire rvalid", 64'(m_r_valid_o), 64'h4);
      check("tmo expire timeout", 64'(timeout_o), 64'h1);
      check("tmo expire rdata", 64'(m_r_rdata_o), 64'hDEAD_BEEF);
      cyc(3'b001, 1, 1, 32'h33);
      check("tmo late rvalid", 64'(m_r_valid_o), 64'h0);
      check("tmo next gnt", 64'(m_gnt_o), 64'h1);
      check("tmo late timeout", 64'(timeout_o), 64'h0);
      cyc(3'b000, 0, 1, 32'h44);
      check("tmo next rvalid", 64'(m_r_valid_o), 64'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/periph_master_arbiter.md
Name: periph_master_arbiter

Overview:
- Round-robin arbiter sharing the single master port of the APB/eFPGA peripheral demux between NB_MASTERS requesters (e.g. FC core, debug module, uDMA config path).
- Sits directly upstream of the demux master port.
- Allows one outstanding transaction at a time and routes the response back to the issuing master by stored index.

Parameters:
- NB_MASTERS, 3, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ID_WIDTH, 10, width of the ID driven to the demux. The low bits carry the master index; the remaining bits are zero.
- TIMEOUT_CYCLES, 256, response timeout. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  NB_MASTERS  per-master request
- m_add_i  in  NB_MASTERS*ADDR_WIDTH  per-master address, packed, master 0 in the LSBs
- m_wen_i  in  NB_MASTERS  per-master write-enable, active low = write
- m_wdata_i  in  NB_MASTERS*DATA_WIDTH  per-master write data
- m_be_i  in  NB_MASTERS*BE_WIDTH  per-master byte enables
- m_gnt_o  out  NB_MASTERS  per-master grant, one-hot or zero
- m_r_valid_o  out  NB_MASTERS  per-master response valid, one-hot or zero
- m_r_rdata_o  out  DATA_WIDTH  response data, shared by all masters
- data_req_o  out  1  request to demux
- data_add_o  out  ADDR_WIDTH  address to demux
- data_wen_o  out  1  write-enable to demux
- data_wdata_o  out  DATA_WIDTH  write data to demux
- data_be_o  out  BE_WIDTH  byte enables to demux
- data_ID_o  out  ID_WIDTH  transaction ID to demux
- data_gnt_i  in  1  demux grant
- data_r_valid_i  in  1  demux response valid
- data_r_rdata_i  in  DATA_WIDTH  demux response data
- timeout_o  out  1  single-cycle pulse on response timeout

Behaviour:
- Single clock clk; reset rst_ni is asynchronous, active-low.
- Reset values:
  - State IDLE; locked=0; rr_ptr=0; sel_q=0; timeout counter 0.
  - All outputs 0, including m_r_rdata_o and timeout_o.
- State machine: IDLE, WAIT_RESP.
- IDLE, unlocked, any m_req_i high:
  - Winner = first requesting index at or after rr_ptr, searching cyclically.
  - data_req_o=1; data_add_o/wen/wdata/be come combinationally from the winner; data_ID_o = winner index.
  - If data_gnt_i=0 the same cycle: latch sel_q=winner, set locked=1.
- IDLE, locked:
  - Keep selecting sel_q regardless of other requests, so the request seen by the demux stays stable.
  - If m_req_i[sel_q] drops (protocol violation), clear locked; no grant is given.
- Grant (IDLE, data_req_o=1 and data_gnt_i=1):
  - m_gnt_o[sel]=1 in the same cycle (combinational pass-through).
  - sel_q<=sel; locked<=0; next state WAIT_RESP.
- WAIT_RESP:
  - data_req_o=0; all m_gnt_o=0; new requests stall.
  - On data_r_valid_i: m_r_valid_o[sel_q]=1 and m_r_rdata_o=data_r_rdata_i in the same cycle (combinational).
  - Then rr_ptr<=(sel_q+1) mod NB_MASTERS; next state IDLE.
- Minimum issue period: a new grant can occur the cycle after a response, so the fastest rate is one transaction per 2 cycles.
- m_r_rdata_o mirrors data_r_rdata_i only when a response is forwarded; otherwise it holds 0.
- data_r_valid_i asserted in IDLE: ignored (no m_r_valid_o), does not change state.
- data_r_valid_i asserted the cycle after a grant (1-cycle slave): accepted normally.
- data_add_o/wdata/be/wen are 0 whenever data_req_o=0.
- rr_ptr wraps from NB_MASTERS-1 to 0.
- Reset asserted mid-transaction: an outstanding response is dropped; masters must reissue.

Optional Feature:
- Macro: PERIPH_ARB_TIMEOUT_EN.
- Enabled:
  - Counter clears on entry to WAIT_RESP and increments each WAIT_RESP cycle without data_r_valid_i.
  - When it reaches TIMEOUT_CYCLES-1 with still no response: m_r_valid_o[sel_q]=1, m_r_rdata_o=32'hDEAD_BEEF (low DATA_WIDTH bits), timeout_o=1 for one cycle, rr_ptr advances, state returns to IDLE.
  - A late data_r_valid_i that arrives afterwards in IDLE is ignored.
  - data_r_valid_i in the same cycle as expiry: the real response wins; no timeout_o.
- Disabled:
  - No counter; WAIT_RESP waits indefinitely.
  - timeout_o tied to 0.

Test Plan:
- Master 1 only requests a write, add=0x1A30_0004, gnt_i same cycle, r_valid 1 cycle later -> m_gnt_o=3'b010 in cycle 0, data_ID_o=1, m_r_valid_o=3'b010 in cycle 1, rr_ptr=2.
- All 3 masters request continuously, slave always grants, responds 1 cycle after grant -> grant order 0,1,2,0,... with one grant every 2 cycles.
- Master 2 requests, gnt_i held low 4 cycles while master 0 also raises req -> data_add_o stays master 2's address all 4 cycles; master 2 is granted first.
- Read from master 0, data_r_rdata_i=0x1234_5678 -> m_r_valid_o=3'b001, m_r_rdata_o=0x1234_5678; spurious r_valid in IDLE produces no m_r_valid_o.
- rst_ni pulsed low while in WAIT_RESP -> all outputs 0 immediately, state IDLE, rr_ptr=0; a subsequent r_valid is ignored.
- With PERIPH_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response after grant -> m_r_valid_o for the issuing master and timeout_o=1 on the 8th WAIT_RESP cycle, rdata 0xDEAD_BEEF, next request accepted.
